// File: rtl/multicycle_control.sv
// multicycle_control: Moore-FSM main control for the multicycle MIPS datapath with memory handshake,
// stall hold and retired-instruction counter; define ILLEGAL_OP_TRAP_EN to trap unknown opcodes.
module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W = 32,
  parameter bit MEM_HS = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               pcwrite,
  output logic               branch_eq,
  output logic               branch_ne,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         pcsrc,
  output logic               illegal,
  output logic [CNT_W-1:0]   instret,
  output logic [3:0]         state
);
  localparam bit TRAP_EN =
`ifdef ILLEGAL_OP_TRAP_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } state_e;
  typedef struct packed {
    logic pcwrite, branch_eq, branch_ne, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic illegal;
  } ctl_t;
  state_e           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy, go, fetch_wait, retire;
  // Control word for a state; the branch flavour is taken from the opcode seen on entry.
  function automatic ctl_t decode(state_e s, logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:          begin c.memread = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; c.irwrite = 1'b1; end
      DECODE:         c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:          begin c.iord = 1'b1; c.memread = 1'b1; end
      MEMWB:          begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:          begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXEC:           begin c.alusrca = 1'b1; c.aluop = 2'd2; end
      ALUWB:          begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      ADDIWB:         c.regwrite = 1'b1;
      BRANCH:         begin c.alusrca = 1'b1; c.aluop = 2'd1; c.pcsrc = 2'b01;
                        c.branch_eq = op == OP_BEQ; c.branch_ne = op == OP_BNE; end
      JUMP:           begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
      TRAP:           if (TRAP_EN) begin c.pcwrite = 1'b1; c.pcsrc = 2'b11; c.illegal = 1'b1; end
      default:        ;
    endcase
    return c;
  endfunction
  assign rdy = MEM_HS ? mem_ready : 1'b1;
  always_comb begin
    state_d = state_q;
    if (!stall)
      case (state_q)
        FETCH:   state_d = rdy ? DECODE : FETCH;
        DECODE:  state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                           opcode == OP_R ? EXEC :
                           opcode == OP_ADDI ? ADDIEX :
                           (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                           opcode == OP_J ? JUMP :
                           TRAP_EN ? TRAP : FETCH;
        MEMADR:  state_d = opcode == OP_SW ? MEMWR : MEMRD;
        MEMRD:   state_d = rdy ? MEMWB : MEMRD;
        MEMWR:   state_d = rdy ? FETCH : MEMWR;
        EXEC:    state_d = ALUWB;
        ADDIEX:  state_d = ADDIWB;
        default: state_d = FETCH;
      endcase
    retire = state_d == FETCH && (state_q inside {MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP});
    instret_d = instret_q + CNT_W'(retire);
    ctl_d = decode(state_d, opcode);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
      ctl_q     <= decode(FETCH, opcode);
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      ctl_q     <= ctl_d;
    end
  end
  // Enables are qualified by reset, stall and, in FETCH, by the memory handshake.
  assign go         = reset_n & ~stall;
  assign fetch_wait = state_q == FETCH && !rdy;
  assign pcwrite    = go & ctl_q.pcwrite & ~fetch_wait;
  assign irwrite    = go & ctl_q.irwrite & ~fetch_wait;
  assign branch_eq  = go & ctl_q.branch_eq;
  assign branch_ne  = go & ctl_q.branch_ne;
  assign regwrite   = go & ctl_q.regwrite;
  assign memread    = go & ctl_q.memread;
  assign memwrite   = go & ctl_q.memwrite;
  assign iord       = reset_n & ctl_q.iord;
  assign memtoreg   = reset_n & ctl_q.memtoreg;
  assign regdst     = reset_n & ctl_q.regdst;
  assign alusrca    = reset_n & ctl_q.alusrca;
  assign alusrcb    = reset_n ? ctl_q.alusrcb : 2'b00;
  assign aluop      = reset_n ? ALUOP_W'(ctl_q.aluop) : '0;
  assign pcsrc      = reset_n ? ctl_q.pcsrc : 2'b00;
  assign illegal    = reset_n & ctl_q.illegal;
  assign instret    = reset_n ? instret_q : '0;
  assign state      = reset_n ? state_q : 4'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven directed check of the multicycle control FSM plus hand-written corner sequences.
module tb_multicycle_control;
  logic        clk = 1'b0, reset_n, mem_ready, stall;
  logic [5:0]  opcode;
  logic        pcwrite, branch_eq, branch_ne, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state;
  int checks = 0, errors = 0, nstep = 0;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
    .pcwrite(pcwrite), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5,
                         S_EXEC = 6, S_ALUWB = 7, S_ADDIEX = 8, S_ADDIWB = 9, S_BRANCH = 10, S_JUMP = 11, S_TRAP = 12;
  // enable order: {pcwrite, branch_eq, branch_ne, irwrite, regwrite, memread, memwrite}
  localparam logic [6:0] E_NONE = 7'b0000000, E_FETCH = 7'b1001010, E_RD = 7'b0000010, E_WR = 7'b0000001,
                         E_RW = 7'b0000100, E_BEQ = 7'b0100000, E_BNE = 7'b0010000, E_PC = 7'b1000000;

  typedef struct {
    logic        rn;
    logic [5:0]  op;
    logic        rdy, stl;
    logic [3:0]  st;
    logic [6:0]  en;
    logic [31:0] ir;
  } vec_t;
  vec_t tbl[28];

  // Datapath selects per state: {iord, memtoreg, regdst, alusrca, alusrcb, aluop, pcsrc, illegal}
  function automatic logic [11:0] exp_mux(logic [3:0] s);
    case (s)
      S_FETCH:            return 12'b0000_01_00_00_0;
      S_DECODE:           return 12'b0000_11_00_00_0;
      S_MEMADR, S_ADDIEX: return 12'b0001_10_00_00_0;
      S_MEMRD, S_MEMWR:   return 12'b1000_00_00_00_0;
      S_MEMWB:            return 12'b0100_00_00_00_0;
      S_EXEC:             return 12'b0001_00_10_00_0;
      S_ALUWB:            return 12'b0010_00_00_00_0;
      S_BRANCH:           return 12'b0001_00_01_01_0;
      S_JUMP:             return 12'b0000_00_00_10_0;
      S_TRAP:             return 12'b0000_00_00_11_1;
      default:            return 12'b0;
    endcase
  endfunction

  function automatic vec_t v(logic rn, logic [5:0] op, logic rdy, logic stl, logic [3:0] st, logic [6:0] en, logic [31:0] ir);
    vec_t x;
    x.rn = rn; x.op = op; x.rdy = rdy; x.stl = stl; x.st = st; x.en = en; x.ir = ir;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, nstep, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic [5:0] op, input logic rdy, input logic stl,
                      input logic [3:0] st, input logic [6:0] en, input logic [31:0] ir);
    reset_n = rn; opcode = op; mem_ready = rdy; stall = stl;
    @(negedge clk);
    chk("state", 32'(state), 32'(st));
    chk("enables", 32'({pcwrite, branch_eq, branch_ne, irwrite, regwrite, memread, memwrite}), 32'(en));
    chk("selects", 32'({iord, memtoreg, regdst, alusrca, alusrcb, aluop, pcsrc, illegal}), 32'(rn ? exp_mux(st) : 12'b0));
    chk("instret", instret, ir);
    nstep++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, lw, sw with 3 wait cycles, beq, bne, stalled R-type
    tbl[0]  = v(0, 6'h00, 1, 0, S_FETCH,  E_NONE,  0);
    tbl[1]  = v(0, 6'h00, 1, 0, S_FETCH,  E_NONE,  0);
    tbl[2]  = v(1, 6'h23, 1, 0, S_FETCH,  E_FETCH, 0);
    tbl[3]  = v(1, 6'h23, 1, 0, S_DECODE, E_NONE,  0);
    tbl[4]  = v(1, 6'h23, 1, 0, S_MEMADR, E_NONE,  0);
    tbl[5]  = v(1, 6'h23, 1, 0, S_MEMRD,  E_RD,    0);
    tbl[6]  = v(1, 6'h23, 1, 0, S_MEMWB,  E_RW,    0);
    tbl[7]  = v(1, 6'h2b, 1, 0, S_FETCH,  E_FETCH, 1);
    tbl[8]  = v(1, 6'h2b, 1, 0, S_DECODE, E_NONE,  1);
    tbl[9]  = v(1, 6'h2b, 1, 0, S_MEMADR, E_NONE,  1);
    tbl[10] = v(1, 6'h2b, 0, 0, S_MEMWR,  E_WR,    1);
    tbl[11] = v(1, 6'h2b, 0, 0, S_MEMWR,  E_WR,    1);
    tbl[12] = v(1, 6'h2b, 0, 0, S_MEMWR,  E_WR,    1);
    tbl[13] = v(1, 6'h2b, 1, 0, S_MEMWR,  E_WR,    1);
    tbl[14] = v(1, 6'h04, 1, 0, S_FETCH,  E_FETCH, 2);
    tbl[15] = v(1, 6'h04, 1, 0, S_DECODE, E_NONE,  2);
    tbl[16] = v(1, 6'h04, 1, 0, S_BRANCH, E_BEQ,   2);
    tbl[17] = v(1, 6'h05, 1, 0, S_FETCH,  E_FETCH, 3);
    tbl[18] = v(1, 6'h05, 1, 0, S_DECODE, E_NONE,  3);
    tbl[19] = v(1, 6'h05, 1, 0, S_BRANCH, E_BNE,   3);
    tbl[20] = v(1, 6'h00, 1, 0, S_FETCH,  E_FETCH, 4);
    tbl[21] = v(1, 6'h00, 1, 0, S_DECODE, E_NONE,  4);
    tbl[22] = v(1, 6'h00, 1, 1, S_EXEC,   E_NONE,  4);
    tbl[23] = v(1, 6'h00, 1, 1, S_EXEC,   E_NONE,  4);
    tbl[24] = v(1, 6'h00, 1, 0, S_EXEC,   E_NONE,  4);
    tbl[25] = v(1, 6'h00, 1, 0, S_ALUWB,  E_RW,    4);
    tbl[26] = v(1, 6'h3f, 1, 0, S_FETCH,  E_FETCH, 5);
    tbl[27] = v(1, 6'h3f, 1, 0, S_DECODE, E_NONE,  5);
    for (int i = 0; i < 28; i++)
      step(tbl[i].rn, tbl[i].op, tbl[i].rdy, tbl[i].stl, tbl[i].st, tbl[i].en, tbl[i].ir);
    // unknown opcode: one-cycle trap or silent return to FETCH, never counted
`ifdef ILLEGAL_OP_TRAP_EN
    step(1, 6'h3f, 1, 0, S_TRAP,   E_PC,    5);
`endif
    // FETCH waiting on memory, then a stall with mem_ready high, then addi
    step(1, 6'h08, 0, 0, S_FETCH,  E_RD,    5);
    step(1, 6'h08, 1, 1, S_FETCH,  E_NONE,  5);
    step(1, 6'h08, 1, 0, S_FETCH,  E_FETCH, 5);
    step(1, 6'h08, 1, 0, S_DECODE, E_NONE,  5);
    step(1, 6'h08, 1, 0, S_ADDIEX, E_NONE,  5);
    step(1, 6'h08, 1, 0, S_ADDIWB, E_RW,    5);
    // jump
    step(1, 6'h02, 1, 0, S_FETCH,  E_FETCH, 6);
    step(1, 6'h02, 1, 0, S_DECODE, E_NONE,  6);
    step(1, 6'h02, 1, 0, S_JUMP,   E_PC,    6);
    // reset in the middle of an instruction clears state and counter
    step(1, 6'h23, 1, 0, S_FETCH,  E_FETCH, 7);
    step(0, 6'h23, 1, 0, S_FETCH,  E_NONE,  0);
    step(1, 6'h23, 1, 0, S_FETCH,  E_FETCH, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
